// File: rtl/wb_fetch.sv
// wb_fetch: Wishbone classic instruction prefetcher feeding a small tagged FIFO.
// One outstanding read at a time; redirects flush the FIFO, bus errors latch a sticky fault.
module wb_fetch #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [7:0]  sel_o,
    output logic [63:0] adr_o,
    output logic [63:0] dat_o,
    input  logic [63:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    output logic [63:0] insn_o,
    output logic [63:0] insn_pc_o,
    output logic        insn_valid_o,
    input  logic        insn_ready_i,
    input  logic        redir_i,
    input  logic [63:0] redir_pc_i,
    output logic        fault_o,
    output logic [63:0] fault_adr_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] CNT_MAX = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD, FAULT} state_t;

    state_t        r_state, w_next;
    logic          r_cyc, r_fault;
    logic [63:0]   r_adr, r_pc, r_fault_adr;
    logic [63:0]   r_mem_d  [FIFO_DEPTH];
    logic [63:0]   r_mem_pc [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_cnt;
    logic          w_issue, w_push, w_err, w_end, w_pop, w_resp;

    assign cyc_o        = r_cyc;
    assign stb_o        = r_cyc;
    assign we_o         = 1'b0;
    assign sel_o        = 8'hff;
    assign adr_o        = r_adr;
    assign dat_o        = '0;
    assign insn_o       = r_mem_d[r_rptr];
    assign insn_pc_o    = r_mem_pc[r_rptr];
    assign insn_valid_o = (r_cnt != '0) && !r_fault;
    assign fault_o      = r_fault;
    assign fault_adr_o  = r_fault_adr;
    assign w_resp       = ack_i | err_i;
    assign w_pop        = insn_valid_o && insn_ready_i && !redir_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // A redirect always wins over a bus response, so pushes and faults require !redir_i.
    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        w_push  = 1'b0;
        w_err   = 1'b0;
        w_end   = 1'b0;
        case (r_state)
            IDLE: begin
                w_issue = !redir_i && (r_cnt < CNT_MAX);
                w_next  = w_issue ? REQ : IDLE;
            end
            REQ: begin
                w_end  = w_resp;
                w_err  = err_i && !redir_i;
                w_push = ack_i && !err_i && !redir_i;
                w_next = redir_i ? (w_resp ? IDLE : DISCARD) :
                         err_i   ? FAULT : ack_i ? IDLE : REQ;
            end
            DISCARD: begin
                w_end  = w_resp;
                w_next = w_resp ? IDLE : DISCARD;
            end
            FAULT:   w_next = redir_i ? IDLE : FAULT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cyc       <= 1'b0;
            r_adr       <= '0;
            r_pc        <= RESET_PC & ~64'h7;
            r_fault     <= 1'b0;
            r_fault_adr <= '0;
        end else begin
            if (w_issue) begin
                r_cyc <= 1'b1;
                r_adr <= r_pc;
            end else if (w_end) begin
                r_cyc <= 1'b0;
            end
            if (redir_i) begin
                r_pc    <= {redir_pc_i[63:3], 3'b000};
                r_fault <= 1'b0;
            end else if (w_push) begin
                r_pc <= r_pc + 64'd8;
            end
            if (w_err) begin
                r_fault     <= 1'b1;
                r_fault_adr <= r_pc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_d[i]  <= '0;
                r_mem_pc[i] <= '0;
            end
        end else if (redir_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_mem_d[r_wptr]  <= dat_i;
                r_mem_pc[r_wptr] <= r_pc;
                r_wptr           <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: tb/tb_wb_fetch.sv
// tb_wb_fetch: directed checks of wb_fetch against a registered-ack boot ROM model.
// A second instance with RESET_PC near the top of memory covers address wrap.
module tb_wb_fetch;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        cyc_o, stb_o, we_o;
    logic [7:0]  sel_o;
    logic [63:0] adr_o, dat_o;
    logic [63:0] dat_i = '0;
    logic        ack_i = 0, err_i = 0;
    logic [63:0] insn_o, insn_pc_o;
    logic        insn_valid_o;
    logic        insn_ready = 0;
    logic        redir = 0;
    logic [63:0] redir_pc = '0;
    logic        fault_o;
    logic [63:0] fault_adr_o;

    logic        w_cyc, w_stb, w_we, w_ack = 0, w_err = 0, w_valid, w_fault;
    logic [7:0]  w_sel;
    logic [63:0] w_adr, w_dato, w_dat = '0, w_insn, w_pc, w_fault_adr;
    logic        w_one = 1, w_zero = 0;
    logic [63:0] w_zpc = '0;

    logic        err_en = 0, stall_en = 0;
    logic [63:0] err_adr = '0, stall_adr = '0;

    int npass = 0, ntot = 0, viol = 0, cyc_cnt = 0;
    logic        prev_stb = 0;
    logic [63:0] prev_adr = '0;
    logic [63:0] bus_q[$], acc_pc[$], acc_insn[$], wbus_q[$], wacc_pc[$], wacc_insn[$];
    int          ack_cyc[$];

    always #5 clk = ~clk;

    wb_fetch u_dut (
        .clk_i(clk), .rst_i(rst_n), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i),
        .err_i(err_i), .insn_o(insn_o), .insn_pc_o(insn_pc_o), .insn_valid_o(insn_valid_o),
        .insn_ready_i(insn_ready), .redir_i(redir), .redir_pc_i(redir_pc),
        .fault_o(fault_o), .fault_adr_o(fault_adr_o)
    );

    wb_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) u_wrap (
        .clk_i(clk), .rst_i(rst_n), .cyc_o(w_cyc), .stb_o(w_stb), .we_o(w_we),
        .sel_o(w_sel), .adr_o(w_adr), .dat_o(w_dato), .dat_i(w_dat), .ack_i(w_ack),
        .err_i(w_err), .insn_o(w_insn), .insn_pc_o(w_pc), .insn_valid_o(w_valid),
        .insn_ready_i(w_one), .redir_i(w_zero), .redir_pc_i(w_zpc),
        .fault_o(w_fault), .fault_adr_o(w_fault_adr)
    );

    // Boot ROM: acks one cycle after it first sees the strobe, data = adr ^ 0xA5A5
    always @(posedge clk) begin
        ack_i <= 0;
        err_i <= 0;
        if (rst_n && cyc_o && stb_o && !ack_i && !err_i && !(stall_en && adr_o == stall_adr)) begin
            if (err_en && adr_o == err_adr) err_i <= 1;
            else begin
                ack_i <= 1;
                dat_i <= adr_o ^ 64'hA5A5;
            end
        end
        w_ack <= rst_n && w_cyc && w_stb && !w_ack;
        w_dat <= w_adr ^ 64'hA5A5;
    end

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (rst_n && cyc_o && stb_o && (ack_i || err_i)) begin
            bus_q.push_back(adr_o);
            ack_cyc.push_back(cyc_cnt);
        end
        if (rst_n && insn_valid_o && insn_ready && !redir) begin
            acc_pc.push_back(insn_pc_o);
            acc_insn.push_back(insn_o);
        end
        if (rst_n && w_cyc && w_ack) wbus_q.push_back(w_adr);
        if (rst_n && w_valid) begin
            wacc_pc.push_back(w_pc);
            wacc_insn.push_back(w_insn);
        end
        if (stb_o && prev_stb && adr_o != prev_adr) viol <= viol + 1;
        prev_stb <= stb_o;
        prev_adr <= adr_o;
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 0;
        redir = 0;
        err_en = 0;
        stall_en = 0;
        repeat (3) @(negedge clk);
        bus_q.delete(); acc_pc.delete(); acc_insn.delete(); ack_cyc.delete();
        wbus_q.delete(); wacc_pc.delete(); wacc_insn.delete();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        @(negedge clk);
        ntot++; if (cyc_o !== 1'b0 || stb_o !== 1'b0) $display("FAIL reset_bus: cyc=%b stb=%b exp 0", cyc_o, stb_o); else npass++;
        ntot++; if (insn_valid_o !== 1'b0) $display("FAIL reset_valid: got %b exp 0", insn_valid_o); else npass++;
        ntot++; if (fault_o !== 1'b0 || fault_adr_o !== 64'h0) $display("FAIL reset_fault: %b %h exp 0 0", fault_o, fault_adr_o); else npass++;
        ntot++; if (insn_o !== 64'h0 || insn_pc_o !== 64'h0) $display("FAIL reset_insn: %h %h exp 0 0", insn_o, insn_pc_o); else npass++;
        ntot++; if (we_o !== 1'b0 || sel_o !== 8'hff || dat_o !== 64'h0) $display("FAIL consts: we=%b sel=%h dat=%h exp 0 ff 0", we_o, sel_o, dat_o); else npass++;
    endtask

    task automatic test_stream();
        apply_reset();
        insn_ready = 1;
        for (int i = 0; i < 60 && acc_pc.size() < 3; i++) @(negedge clk);
        ntot++; if (acc_pc.size() < 3) $display("FAIL stream_timeout: got %0d words exp 3", acc_pc.size()); else npass++;
        ntot++; if (acc_pc[0] !== 64'h0 || acc_insn[0] !== 64'hA5A5) $display("FAIL stream_w0: pc %h insn %h exp 0 a5a5", acc_pc[0], acc_insn[0]); else npass++;
        ntot++; if (acc_pc[1] !== 64'h8 || acc_insn[1] !== 64'hA5AD) $display("FAIL stream_w1: pc %h insn %h exp 8 a5ad", acc_pc[1], acc_insn[1]); else npass++;
        ntot++; if (acc_pc[2] !== 64'h10 || acc_insn[2] !== 64'hA5B5) $display("FAIL stream_w2: pc %h insn %h exp 10 a5b5", acc_pc[2], acc_insn[2]); else npass++;
        ntot++; if (bus_q[0] !== 64'h0 || bus_q[1] !== 64'h8 || bus_q[2] !== 64'h10) $display("FAIL stream_adr: %h %h %h exp 0 8 10", bus_q[0], bus_q[1], bus_q[2]); else npass++;
        ntot++; if (ack_cyc[1] - ack_cyc[0] != 3) $display("FAIL stream_rate: got %0d cycles exp 3", ack_cyc[1] - ack_cyc[0]); else npass++;
    endtask

    task automatic test_backpressure();
        insn_ready = 0;
        apply_reset();
        repeat (30) @(negedge clk);
        ntot++; if (bus_q.size() != 4) $display("FAIL bp_count: got %0d fetches exp 4", bus_q.size()); else npass++;
        ntot++; if (cyc_o !== 1'b0) $display("FAIL bp_cyc: got %b exp 0", cyc_o); else npass++;
        ntot++; if (insn_valid_o !== 1'b1 || insn_pc_o !== 64'h0 || insn_o !== 64'hA5A5) $display("FAIL bp_head: v=%b pc=%h insn=%h exp 1 0 a5a5", insn_valid_o, insn_pc_o, insn_o); else npass++;
        insn_ready = 1;
        for (int i = 0; i < 100 && acc_pc.size() < 5; i++) @(negedge clk);
        ntot++; if (acc_pc.size() < 5) $display("FAIL bp_timeout: got %0d words exp 5", acc_pc.size()); else npass++;
        ntot++; if (acc_pc[0] !== 64'h0 || acc_pc[1] !== 64'h8 || acc_pc[2] !== 64'h10 || acc_pc[3] !== 64'h18)
            $display("FAIL bp_order: %h %h %h %h exp 0 8 10 18", acc_pc[0], acc_pc[1], acc_pc[2], acc_pc[3]); else npass++;
        ntot++; if (acc_pc[4] !== 64'h20 || bus_q[4] !== 64'h20) $display("FAIL bp_resume: pc %h adr %h exp 20 20", acc_pc[4], bus_q[4]); else npass++;
    endtask

    task automatic test_fault();
        int n, busy;
        apply_reset();
        insn_ready = 1;
        err_en = 1;
        err_adr = 64'h18;
        for (int i = 0; i < 100 && !fault_o; i++) @(negedge clk);
        ntot++; if (fault_o !== 1'b1 || fault_adr_o !== 64'h18) $display("FAIL fault_set: %b %h exp 1 18", fault_o, fault_adr_o); else npass++;
        ntot++; if (insn_valid_o !== 1'b0) $display("FAIL fault_valid: got %b exp 0", insn_valid_o); else npass++;
        ntot++; if (acc_pc.size() != 3) $display("FAIL fault_words: got %0d exp 3", acc_pc.size()); else npass++;
        busy = 0;
        repeat (10) begin @(negedge clk); if (cyc_o) busy++; end
        ntot++; if (busy != 0) $display("FAIL fault_quiet: cyc high %0d cycles exp 0", busy); else npass++;
        err_en = 0;
        n = bus_q.size();
        redir = 1;
        redir_pc = 64'h40;
        @(negedge clk);
        redir = 0;
        ntot++; if (fault_o !== 1'b0) $display("FAIL fault_clear: got %b exp 0", fault_o); else npass++;
        for (int i = 0; i < 40 && bus_q.size() <= n; i++) @(negedge clk);
        ntot++; if (bus_q[n] !== 64'h40) $display("FAIL fault_redir_adr: got %h exp 40", bus_q[n]); else npass++;
    endtask

    task automatic test_discard();
        int n;
        apply_reset();
        insn_ready = 1;
        stall_en = 1;
        stall_adr = 64'h10;
        for (int i = 0; i < 60 && !(cyc_o && adr_o == 64'h10); i++) @(negedge clk);
        @(negedge clk);
        n = bus_q.size();
        redir = 1;
        redir_pc = 64'h103;
        @(negedge clk);
        redir = 0;
        acc_pc.delete();
        acc_insn.delete();
        ntot++; if (cyc_o !== 1'b1 || adr_o !== 64'h10) $display("FAIL disc_hold: cyc=%b adr=%h exp 1 10", cyc_o, adr_o); else npass++;
        ntot++; if (insn_valid_o !== 1'b0) $display("FAIL disc_valid: got %b exp 0", insn_valid_o); else npass++;
        stall_en = 0;
        for (int i = 0; i < 60 && acc_pc.size() < 1; i++) @(negedge clk);
        ntot++; if (bus_q[n] !== 64'h10 || bus_q[n+1] !== 64'h100) $display("FAIL disc_adr: %h %h exp 10 100", bus_q[n], bus_q[n+1]); else npass++;
        ntot++; if (acc_pc[0] !== 64'h100 || acc_insn[0] !== 64'hA4A5) $display("FAIL disc_first: pc %h insn %h exp 100 a4a5", acc_pc[0], acc_insn[0]); else npass++;
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 60 && wbus_q.size() < 2; i++) @(negedge clk);
        ntot++; if (wbus_q[0] !== 64'hFFFF_FFFF_FFFF_FFF8 || wbus_q[1] !== 64'h0) $display("FAIL wrap_adr: %h %h exp fffffffffffffff8 0", wbus_q[0], wbus_q[1]); else npass++;
        ntot++; if (wacc_pc[0] !== 64'hFFFF_FFFF_FFFF_FFF8 || wacc_insn[0] !== 64'hFFFF_FFFF_FFFF_5A5D)
            $display("FAIL wrap_insn: pc %h insn %h exp fffffffffffffff8 ffffffffffff5a5d", wacc_pc[0], wacc_insn[0]); else npass++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        insn_ready = 1;
        stall_en = 1;
        stall_adr = 64'h8;
        for (int i = 0; i < 60 && !(cyc_o && adr_o == 64'h8); i++) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        ntot++; if (cyc_o !== 1'b0 || stb_o !== 1'b0) $display("FAIL async_drop: cyc=%b stb=%b exp 0 0", cyc_o, stb_o); else npass++;
        repeat (2) @(negedge clk);
        stall_en = 0;
        bus_q.delete(); acc_pc.delete(); acc_insn.delete();
        rst_n = 1;
        ntot++; if (insn_valid_o !== 1'b0) $display("FAIL async_empty: got %b exp 0", insn_valid_o); else npass++;
        for (int i = 0; i < 60 && acc_pc.size() < 1; i++) @(negedge clk);
        ntot++; if (bus_q[0] !== 64'h0 || acc_pc[0] !== 64'h0) $display("FAIL async_restart: adr %h pc %h exp 0 0", bus_q[0], acc_pc[0]); else npass++;
    endtask

    task automatic test_spacing();
        ntot++; if (viol != 0) $display("FAIL stb_spacing: got %0d back-to-back address changes exp 0", viol); else npass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_fault();
        test_discard();
        test_wrap();
        test_async_reset();
        test_spacing();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
